// File: rtl/note_pkg.sv
// Shared constants, parser states and the note key table for the note selector.
package note_pkg;

    localparam logic [4:0] EMPTY_ID  = 5'd31;
    localparam int         NUM_NOTES = 25;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } parse_state_t;

    // Set-2 make codes indexed by note id: lower row (Z..M) then upper row (Q..I).
    localparam logic [7:0] NOTE_CODE [NUM_NOTES] = '{
        8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
        8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
        8'h43
    };

endpackage

// File: rtl/note_key_rom.sv
// Combinational scan-code to note-id lookup.
module note_key_rom
    import note_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic [4:0] o_id
);

    // Linear match against the key table; codes are unique so at most one entry hits.
    always_comb begin
        o_hit = 1'b0;
        o_id  = EMPTY_ID;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (i_code == NOTE_CODE[i]) begin
                o_hit = 1'b1;
                o_id  = 5'(i);
            end
        end
    end

endmodule

// File: rtl/note_select.sv
// Tracks up to two held note keys from PS/2 scan codes and publishes their
// ids once per frame with a one-frame new_f strobe.
//
// state   | meaning
// IDLE    | waiting for a key byte; plain codes are make events
// BRK     | F0 seen; next code is a break event
// EXT     | E0 seen; extended keys are never notes
// EXT_BRK | E0 F0 seen; next code is swallowed
module note_select
    import note_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       vsync,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [4:0] freq_id1,
    output logic [4:0] freq_id2,
    output logic       new_f
);

    parse_state_t r_state;
    parse_state_t w_state_nx;

    logic [4:0] r_slot1;
    logic [4:0] r_slot2;
    logic [4:0] r_freq_id1;
    logic [4:0] r_freq_id2;
    logic       r_new_f;
    logic       r_pending;
    logic       r_vsync_d;

    logic       w_make;
    logic       w_brk;
    logic       w_hit;
    logic [4:0] w_id;
    logic [4:0] w_slot1_nx;
    logic [4:0] w_slot2_nx;
    logic       w_slot_change;
    logic       w_fe;

    note_key_rom u_rom (
        .i_code (code),
        .o_hit  (w_hit),
        .o_id   (w_id)
    );

    assign w_fe = r_vsync_d & ~vsync;

    // Parser next state and event decode; only code_valid cycles advance it.
    always_comb begin
        w_state_nx = r_state;
        w_make     = 1'b0;
        w_brk      = 1'b0;
        if (code_valid) begin
            case (r_state)
                IDLE: begin
                    if (code == SC_EXT) begin
                        w_state_nx = EXT;
                    end else if (code == SC_BRK) begin
                        w_state_nx = BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                BRK: begin
                    w_brk      = 1'b1;
                    w_state_nx = IDLE;
                end
                EXT: begin
                    w_state_nx = (code == SC_BRK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // Slot update rules; slot1 is kept filled first so slot2 is only used when slot1 holds a note.
    always_comb begin
        w_slot1_nx = r_slot1;
        w_slot2_nx = r_slot2;
        if (w_make && w_hit) begin
            if ((w_id == r_slot1) || (w_id == r_slot2)) begin
                w_slot1_nx = r_slot1;
            end else if (r_slot1 == EMPTY_ID) begin
                w_slot1_nx = w_id;
            end else begin
                // slot2 empty, or both full and the newest key replaces slot2
                w_slot2_nx = w_id;
            end
        end else if (w_brk && w_hit) begin
            if (w_id == r_slot1) begin
                w_slot1_nx = r_slot2;
                w_slot2_nx = EMPTY_ID;
            end else if (w_id == r_slot2) begin
                w_slot2_nx = EMPTY_ID;
            end
        end
    end

    assign w_slot_change = (w_slot1_nx != r_slot1) || (w_slot2_nx != r_slot2);

    // Parser state and held-key slots.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_slot1 <= EMPTY_ID;
            r_slot2 <= EMPTY_ID;
        end else begin
            r_state <= w_state_nx;
            r_slot1 <= w_slot1_nx;
            r_slot2 <= w_slot2_nx;
        end
    end

    // Frame-aligned publish: a strobe after a strobe is suppressed so new_f always has a low frame between pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vsync_d  <= 1'b1;
            r_new_f    <= 1'b0;
            r_freq_id1 <= EMPTY_ID;
            r_freq_id2 <= EMPTY_ID;
        end else begin
            r_vsync_d <= vsync;
            if (w_fe) begin
                if (r_new_f) begin
                    r_new_f <= 1'b0;
                end else if (r_pending) begin
                    r_freq_id1 <= r_slot1;
                    r_freq_id2 <= r_slot2;
                    r_new_f    <= 1'b1;
                end
            end
        end
    end

    // Pending change flag; a slot change in the latch cycle wins so it is published at a later frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_slot_change) begin
            r_pending <= 1'b1;
        end else if (w_fe && !r_new_f && r_pending) begin
            r_pending <= 1'b0;
        end
    end

    assign freq_id1 = r_freq_id1;
    assign freq_id2 = r_freq_id2;
    assign new_f    = r_new_f;

endmodule

// File: tb/tb_note_select.sv
// Self-checking bench for note_select: scoreboard of expected strobe ids,
// a monitor enforcing frame-aligned output changes, and directed scenarios.
module tb_note_select;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b1;
    logic [7:0] code = 8'h00;
    logic       code_valid = 1'b0;
    logic [4:0] freq_id1;
    logic [4:0] freq_id2;
    logic       new_f;

    logic [7:0] rom_code = 8'h00;
    logic       rom_hit;
    logic [4:0] rom_id;

    int errors = 0;
    int checks = 0;

    logic [9:0] sb[$];

    logic [7:0] key_tbl [25] = '{
        8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
        8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
        8'h43
    };

    note_select dut (
        .clock      (clock),
        .reset      (reset),
        .vsync      (vsync),
        .code       (code),
        .code_valid (code_valid),
        .freq_id1   (freq_id1),
        .freq_id2   (freq_id2),
        .new_f      (new_f)
    );

    note_key_rom rom (
        .i_code (rom_code),
        .o_hit  (rom_hit),
        .o_id   (rom_id)
    );

    always #5 clock = ~clock;

    // Monitor: outputs may only move the cycle after a vsync fall; each rising strobe pops the scoreboard.
    initial begin
        logic       vs_q;
        logic       fall_pend;
        logic       allowed;
        logic       p_new;
        logic [4:0] p1;
        logic [4:0] p2;
        logic [9:0] exp_ids;
        vs_q = 1'b1;
        fall_pend = 1'b0;
        p_new = 1'b0;
        p1 = 5'd31;
        p2 = 5'd31;
        forever begin
            @(negedge clock);
            allowed   = fall_pend;
            fall_pend = vs_q & ~vsync;
            vs_q      = vsync;
            if (!reset) begin
                if (new_f && !p_new) begin
                    checks++;
                    if (!allowed) begin
                        errors++;
                        $display("FAIL strobe_timing: new_f rose at %0t, required one cycle after a vsync fall", $time);
                    end
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: ids %0d/%0d at %0t, required no strobe", freq_id1, freq_id2, $time);
                    end else begin
                        exp_ids = sb.pop_front();
                        checks++;
                        if ({freq_id1, freq_id2} !== exp_ids) begin
                            errors++;
                            $display("FAIL strobe_ids: got %0d/%0d, required %0d/%0d", freq_id1, freq_id2, exp_ids[9:5], exp_ids[4:0]);
                        end
                    end
                end else if (new_f !== p_new || freq_id1 !== p1 || freq_id2 !== p2) begin
                    checks++;
                    if (!allowed || new_f) begin
                        errors++;
                        $display("FAIL output_moved: new_f=%0b ids=%0d/%0d at %0t, required no change without a strobe", new_f, freq_id1, freq_id2, $time);
                    end
                end
                if (allowed && p_new) begin
                    checks++;
                    if (new_f !== 1'b0) begin
                        errors++;
                        $display("FAIL strobe_length: new_f=%0b after second frame edge, required 0", new_f);
                    end
                end
            end
            p_new = new_f;
            p1 = freq_id1;
            p2 = freq_id2;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clock);
        #1 code = b;
        code_valid = 1'b1;
        @(posedge clock);
        #1 code_valid = 1'b0;
    endtask

    // Drives vsync low; returns at the negedge after the DUT's frame-edge cycle.
    task automatic frame_edge();
        @(posedge clock);
        #1 vsync = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Frame edge with a make code presented in the very cycle the DUT sees the edge.
    task automatic frame_edge_with(input logic [7:0] b);
        @(posedge clock);
        #1 vsync = 1'b0;
        code = b;
        code_valid = 1'b1;
        @(posedge clock);
        #1 code_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic frame_rest();
        @(posedge clock);
        #1 vsync = 1'b1;
        repeat (18) @(posedge clock);
    endtask

    task automatic frame();
        frame_edge();
        frame_rest();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL reset_values: got new_f=%0b ids=%0d/%0d, required 0 31/31", new_f, freq_id1, freq_id2);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        repeat (3) frame();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL idle_frames: got new_f=%0b ids=%0d/%0d, required 0 31/31", new_f, freq_id1, freq_id2);
        end
    endtask

    task automatic test_single_repeat();
        send(8'h1A);
        send(8'h1A);
        send(8'h1A);
        sb.push_back({5'd0, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL repeat_strobe: got new_f=%0b ids=%0d/%0d, required 1 0/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL repeat_single: got new_f=%0b ids=%0d/%0d, required 0 0/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
    endtask

    task automatic test_newest_wins();
        send(8'h15);
        send(8'h43);
        sb.push_back({5'd0, 5'd24});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd24}) begin
            errors++;
            $display("FAIL newest_wins: got new_f=%0b ids=%0d/%0d, required 1 0/24", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
    endtask

    task automatic test_release();
        send(8'hF0);
        send(8'h1A);
        sb.push_back({5'd24, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd24, 5'd31}) begin
            errors++;
            $display("FAIL release_compact: got new_f=%0b ids=%0d/%0d, required 1 24/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        send(8'hF0);
        send(8'h43);
        sb.push_back({5'd31, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd24, 5'd31}) begin
            errors++;
            $display("FAIL release_gap: got new_f=%0b ids=%0d/%0d, required 0 24/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL release_all: got new_f=%0b ids=%0d/%0d, required 1 31/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
    endtask

    task automatic test_fe_collision();
        frame_edge_with(8'h1A);
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL collide_idle: got new_f=%0b ids=%0d/%0d, required 0 31/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        sb.push_back({5'd0, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL collide_late: got new_f=%0b ids=%0d/%0d, required 1 0/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
        // pending already set when a second change lands on the frame edge
        send(8'hF0);
        send(8'h1A);
        sb.push_back({5'd31, 5'd31});
        frame_edge_with(8'h1B);
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL collide_pre: got new_f=%0b ids=%0d/%0d, required 1 31/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame_edge();
        frame_rest();
        sb.push_back({5'd1, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd1, 5'd31}) begin
            errors++;
            $display("FAIL collide_post: got new_f=%0b ids=%0d/%0d, required 1 1/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
        send(8'hF0);
        send(8'h1B);
        sb.push_back({5'd31, 5'd31});
        frame();
        frame();
    endtask

    task automatic test_back_to_back();
        send(8'h1A);
        sb.push_back({5'd0, 5'd31});
        frame();
        send(8'h1B);
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL b2b_gap: got new_f=%0b ids=%0d/%0d, required 0 0/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        sb.push_back({5'd0, 5'd1});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL b2b_second: got new_f=%0b ids=%0d/%0d, required 1 0/1", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
        send(8'hF0);
        send(8'h1A);
        send(8'hF0);
        send(8'h1B);
        sb.push_back({5'd31, 5'd31});
        frame();
        frame();
    endtask

    task automatic test_extended();
        send(8'hE0);
        send(8'h1A);
        send(8'hE0);
        send(8'hF0);
        send(8'h1A);
        send(8'h1C);
        send(8'hF0);
        send(8'h1B);
        frame();
        frame();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL extended_ignored: got new_f=%0b ids=%0d/%0d, required 0 31/31", new_f, freq_id1, freq_id2);
        end
        send(8'h1A);
        sb.push_back({5'd0, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL parser_resync: got new_f=%0b ids=%0d/%0d, required 1 0/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
    endtask

    task automatic test_reset_strobe();
        send(8'h1B);
        sb.push_back({5'd0, 5'd1});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL pre_reset_strobe: got new_f=%0b ids=%0d/%0d, required 1 0/1", new_f, freq_id1, freq_id2);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        vsync = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b0, 5'd31, 5'd31}) begin
            errors++;
            $display("FAIL reset_mid_strobe: got new_f=%0b ids=%0d/%0d, required 0 31/31", new_f, freq_id1, freq_id2);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        frame();
        frame();
        send(8'h1B);
        sb.push_back({5'd1, 5'd31});
        frame_edge();
        checks++;
        if ({new_f, freq_id1, freq_id2} !== {1'b1, 5'd1, 5'd31}) begin
            errors++;
            $display("FAIL reset_cleared_slots: got new_f=%0b ids=%0d/%0d, required 1 1/31", new_f, freq_id1, freq_id2);
        end
        frame_rest();
        frame();
    endtask

    task automatic test_key_rom();
        logic       exp_hit;
        logic [4:0] exp_id;
        for (int c = 0; c < 256; c++) begin
            rom_code = 8'(c);
            exp_hit = 1'b0;
            exp_id = 5'd0;
            for (int k = 0; k < 25; k++) begin
                if (key_tbl[k] == 8'(c)) begin
                    exp_hit = 1'b1;
                    exp_id = 5'(k);
                end
            end
            #1;
            checks++;
            if (rom_hit !== exp_hit || (exp_hit && rom_id !== exp_id)) begin
                errors++;
                $display("FAIL key_rom: code %h got hit=%0b id=%0d, required hit=%0b id=%0d", c[7:0], rom_hit, rom_id, exp_hit, exp_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_repeat();
        test_newest_wins();
        test_release();
        test_fe_collision();
        test_back_to_back();
        test_extended();
        test_reset_strobe();
        test_key_rom();
        repeat (2) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
